// File: rtl/biquad_coeff_pkg.sv
// Shared constants for the biquad coefficient loader: register map, CTRL bit
// positions and sequencer state encoding.
package biquad_coeff_pkg;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_PTR   = 2'd1;
    localparam logic [1:0] REG_COEFF = 2'd2;
    localparam logic [1:0] REG_RSVD  = 2'd3;

    localparam int CTRL_LOAD_BIT = 0;
    localparam int CTRL_BUSY_BIT = 0;
    localparam int CTRL_PEND_BIT = 1;
    localparam int CTRL_MASK_LSB = 8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_STREAM = 2'd1;
    localparam state_t ST_UPDATE = 2'd2;

endpackage

// File: rtl/biquad_coeff_loader_if.sv
// WISHBONE classic slave bus used to program the coefficient loader.
interface biquad_coeff_loader_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [6:0]  adr;
    logic [31:0] datW;
    logic [3:0]  sel;
    logic        ack;
    logic [31:0] datR;

    modport master (output cyc, stb, we, adr, datW, sel, input ack, datR);
    modport slave  (input cyc, stb, we, adr, datW, sel, output ack, datR);
endinterface

// File: rtl/biquad_coeff_ram.sv
// Shadow coefficient store: one write port, one registered read port whose
// address is taken from the sequencer while streaming and from the bus pointer otherwise.
module biquad_coeff_ram #(
    parameter int AW    = 5,
    parameter int CBITS = 18
) (
    input  logic             clk_i,
    input  logic             wrEn_i,
    input  logic [AW-1:0]    wrAddr_i,
    input  logic [CBITS-1:0] wrData_i,
    input  logic             seqSel_i,
    input  logic [AW-1:0]    seqAddr_i,
    input  logic [AW-1:0]    busAddr_i,
    output logic [CBITS-1:0] rdData_o
);
    logic [CBITS-1:0] mem_q [2**AW];
    logic [CBITS-1:0] rdData_q;
    logic [AW-1:0]    rdAddr;

    assign rdAddr = seqSel_i ? seqAddr_i : busAddr_i;

    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
        rdData_q <= mem_q[rdAddr];
    end

    assign rdData_o = rdData_q;
endmodule

// File: rtl/biquad_coeff_loader.sv
// WISHBONE coefficient manager: software fills a shadow RAM, a LOAD streams the
// selected channels into the filter chains and ends with one shared update strobe.
module biquad_coeff_loader
    import biquad_coeff_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int NCOEFF = 8,
    parameter int CBITS  = 18
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    biquad_coeff_loader_if.slave wb,
    input  logic                 global_update_i,
    output logic [CBITS-1:0]     coeff_dat_o,
    output logic [NCH-1:0]       coeff_wr_o,
    output logic [NCH-1:0]       coeff_update_o,
    output logic                 busy_o
);
    localparam int DEPTH = NCH * NCOEFF;
    localparam int AW    = $clog2(DEPTH);
    localparam int KW    = $clog2(NCOEFF);
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [KW-1:0] LAST_K    = KW'(NCOEFF - 1);

    // Lowest set mask bit at or above 'from'; MSB of the result flags a hit.
    function automatic logic [CHW:0] findChannel(input logic [NCH-1:0] mask, input int from);
        logic [CHW:0] result;
        result = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) begin
                result = {1'b1, CHW'(i)};
            end
        end
        return result;
    endfunction

    state_t           state_q, state_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic [KW-1:0]    k_q, k_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic             pending_q, pending_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic [1:0]       rdIdx_q, rdIdx_d;
    logic [31:0]      rdData_q, rdData_d;
    logic [CBITS-1:0] coeffDat_q, coeffDat_d;
    logic [NCH-1:0]   coeffWr_q, coeffWr_d;
    logic [NCH-1:0]   coeffUpd_q, coeffUpd_d;

    logic             req, stallWr, accept, wrAccept, rdAccept, loadAccept, coeffWrite;
    logic [1:0]       regIdx;
    logic [NCH-1:0]   newMask;
    logic [CHW:0]     firstCh, nextCh;
    logic [CBITS-1:0] ramDout;
    logic [AW-1:0]    seqAddr;
    logic             seqRead;
    logic             unusedBits;

    assign regIdx     = wb.adr[3:2];
    assign req        = wb.cyc & wb.stb;
    assign stallWr    = wb.we && (regIdx != REG_RSVD) && busy_q;
    assign accept     = req && !ack_q && !stallWr;
    assign wrAccept   = accept && wb.we;
    assign rdAccept   = accept && !wb.we;
    assign newMask    = wb.datW[CTRL_MASK_LSB +: NCH];
    assign loadAccept = wrAccept && (regIdx == REG_CTRL) && wb.datW[CTRL_LOAD_BIT]
                        && (newMask != '0) && (state_q == ST_IDLE);
    assign coeffWrite = wrAccept && (regIdx == REG_COEFF);
    assign firstCh    = findChannel(newMask, 0);
    assign nextCh     = findChannel(mask_q, int'(ch_q) + 1);

    assign unusedBits = ^{wb.sel, wb.adr[6:4], wb.adr[1:0], wb.datW, firstCh[CHW]};

    always_comb begin
        ack_d    = accept;
        rdIdx_d  = rdIdx_q;
        rdData_d = rdData_q;
        ptr_d    = ptr_q;
        if (rdAccept) begin
            rdIdx_d  = regIdx;
            rdData_d = '0;
            case (regIdx)
                REG_CTRL: begin
                    rdData_d[CTRL_BUSY_BIT]          = busy_q;
                    rdData_d[CTRL_PEND_BIT]          = pending_q;
                    rdData_d[CTRL_MASK_LSB +: NCH]   = mask_q;
                end
                REG_PTR: rdData_d = 32'(ptr_q);
                default: rdData_d = '0;
            endcase
        end
        if (wrAccept && (regIdx == REG_PTR)) begin
            ptr_d = wb.datW[AW-1:0];
        end else if (coeffWrite) begin
            ptr_d = (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;
        end
    end

    // Sequencer: the RAM address for the next stream beat is issued a cycle
    // early so that its registered read lines up with the registered strobe.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        k_d        = k_q;
        mask_d     = mask_q;
        pending_d  = pending_q;
        coeffDat_d = coeffDat_q;
        coeffWr_d  = '0;
        coeffUpd_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (loadAccept) begin
                    state_d   = ST_STREAM;
                    mask_d    = newMask;
                    ch_d      = firstCh[CHW-1:0];
                    k_d       = '0;
                    pending_d = global_update_i;
                end else if (global_update_i) begin
                    coeffUpd_d = '1;
                end
            end
            ST_STREAM: begin
                coeffDat_d = ramDout;
                coeffWr_d  = NCH'(1) << ch_q;
                if (global_update_i) begin
                    pending_d = 1'b1;
                end
                if (k_q == LAST_K) begin
                    k_d = '0;
                    if (nextCh[CHW]) begin
                        ch_d = nextCh[CHW-1:0];
                    end else begin
                        state_d = ST_UPDATE;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_UPDATE: begin
                coeffUpd_d = (pending_q || global_update_i) ? '1 : mask_q;
                pending_d  = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Busy also covers the UPDATE strobe cycle, so bus writes stay stalled until it is out.
    assign busy_d  = (state_q != ST_IDLE) || (state_d != ST_IDLE);
    assign seqRead = (state_d == ST_STREAM);
    assign seqAddr = AW'({ch_d, k_d});

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            k_q        <= '0;
            mask_q     <= '0;
            pending_q  <= 1'b0;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            rdIdx_q    <= REG_CTRL;
            rdData_q   <= '0;
            coeffDat_q <= '0;
            coeffWr_q  <= '0;
            coeffUpd_q <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            k_q        <= k_d;
            mask_q     <= mask_d;
            pending_q  <= pending_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            rdIdx_q    <= rdIdx_d;
            rdData_q   <= rdData_d;
            coeffDat_q <= coeffDat_d;
            coeffWr_q  <= coeffWr_d;
            coeffUpd_q <= coeffUpd_d;
        end
    end

    biquad_coeff_ram #(
        .AW    (AW),
        .CBITS (CBITS)
    ) uRam (
        .clk_i     (clk_i),
        .wrEn_i    (coeffWrite),
        .wrAddr_i  (ptr_q),
        .wrData_i  (wb.datW[CBITS-1:0]),
        .seqSel_i  (seqRead),
        .seqAddr_i (seqAddr),
        .busAddr_i (ptr_q),
        .rdData_o  (ramDout)
    );

    assign wb.ack         = ack_q;
    assign wb.datR        = !ack_q ? '0 :
                            (rdIdx_q == REG_COEFF) ? 32'(signed'(ramDout)) : rdData_q;
    assign coeff_dat_o    = coeffDat_q;
    assign coeff_wr_o     = coeffWr_q;
    assign coeff_update_o = coeffUpd_q;
    assign busy_o         = busy_q;
endmodule

// File: tb/tb_biquad_coeff_loader.sv
// Scoreboard bench for biquad_coeff_loader: directed bus traffic pushes expected
// acks, strobes, update masks and busy/run lengths; a monitor pops and compares.
module tb_biquad_coeff_loader;
    localparam int NCH    = 4;
    localparam int NCOEFF = 8;
    localparam int CBITS  = 18;

    localparam logic [6:0] ADR_CTRL  = 7'h00;
    localparam logic [6:0] ADR_PTR   = 7'h04;
    localparam logic [6:0] ADR_COEFF = 7'h08;
    localparam logic [6:0] ADR_RSVD  = 7'h0C;

    typedef struct {
        bit          isRead;
        logic [31:0] data;
    } busExp_t;

    typedef struct {
        logic [NCH-1:0]   wr;
        logic [CBITS-1:0] dat;
    } wrExp_t;

    logic             clock = 1'b0;
    logic             resetN;
    logic             globalUpdate;
    logic [CBITS-1:0] coeffDat;
    logic [NCH-1:0]   coeffWr;
    logic [NCH-1:0]   coeffUpd;
    logic             busy;

    busExp_t          busQ[$];
    wrExp_t           wrQ[$];
    logic [NCH-1:0]   updQ[$];
    int               busyQ[$];
    int               runQ[$];
    logic [CBITS-1:0] shadow [NCH*NCOEFF];

    int      checks = 0;
    int      passes = 0;
    int      busyCnt = 0;
    int      runCnt = 0;
    int      waited;
    busExp_t eBus;
    wrExp_t  eWr;

    biquad_coeff_loader_if wb();

    biquad_coeff_loader #(
        .NCH    (NCH),
        .NCOEFF (NCOEFF),
        .CBITS  (CBITS)
    ) dut (
        .clk_i           (clock),
        .rst_ni          (resetN),
        .wb              (wb),
        .global_update_i (globalUpdate),
        .coeff_dat_o     (coeffDat),
        .coeff_wr_o      (coeffWr),
        .coeff_update_o  (coeffUpd),
        .busy_o          (busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        $display("[TB] FAIL %s: event did not match expectation", name);
    endtask

    task automatic applyStimulus(input bit we, input logic [6:0] adr, input logic [31:0] dat,
                                 input logic [31:0] expRd, output int nWait);
        busExp_t e;
        bit      gotAck;
        e.isRead = !we;
        e.data   = expRd;
        busQ.push_back(e);
        wb.cyc  = 1'b1;
        wb.stb  = 1'b1;
        wb.we   = we;
        wb.adr  = adr;
        wb.datW = dat;
        wb.sel  = 4'hF;
        nWait   = 0;
        gotAck  = 1'b0;
        while (!gotAck && nWait < 200) begin
            @(posedge clock);
            #1;
            nWait++;
            gotAck = wb.ack;
        end
        wb.cyc = 1'b0;
        wb.stb = 1'b0;
        wb.we  = 1'b0;
        if (!gotAck) failNow("ackTimeout");
    endtask

    task automatic busWrite(input logic [6:0] adr, input logic [31:0] dat);
        int n;
        applyStimulus(1'b1, adr, dat, 32'h0, n);
    endtask

    task automatic busRead(input logic [6:0] adr, input logic [31:0] expected);
        int n;
        applyStimulus(1'b0, adr, 32'h0, expected, n);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (busy) failNow("busyTimeout");
    endtask

    task automatic expectStream(input int ch, input int count, input logic [NCH-1:0] wr);
        wrExp_t e;
        for (int k = 0; k < count; k++) begin
            e.wr  = wr;
            e.dat = shadow[ch*NCOEFF + k];
            wrQ.push_back(e);
        end
    endtask

    // Monitor: samples on the falling edge and retires scoreboard entries.
    initial begin : monitor
        forever begin
            @(negedge clock);
            if (wb.ack) begin
                if (busQ.size() == 0) begin
                    failNow("ackUnexpected");
                end else begin
                    eBus = busQ.pop_front();
                    if (eBus.isRead) checkOutput("rdData", wb.datR, eBus.data);
                end
            end
            if (coeffWr != '0) begin
                runCnt++;
                if (wrQ.size() == 0) begin
                    failNow("coeffWrUnexpected");
                end else begin
                    eWr = wrQ.pop_front();
                    checkOutput("coeffWr", 32'(coeffWr), 32'(eWr.wr));
                    checkOutput("coeffDat", 32'(coeffDat), 32'(eWr.dat));
                end
            end else if (runCnt > 0) begin
                if (runQ.size() == 0) failNow("wrRunUnexpected");
                else checkOutput("wrRunLength", 32'(runCnt), 32'(runQ.pop_front()));
                runCnt = 0;
            end
            if (coeffUpd != '0) begin
                if (updQ.size() == 0) failNow("updateUnexpected");
                else checkOutput("coeffUpdate", 32'(coeffUpd), 32'(updQ.pop_front()));
            end
            if (busy) begin
                busyCnt++;
            end else if (busyCnt > 0) begin
                if (busyQ.size() == 0) failNow("busyUnexpected");
                else checkOutput("busyLength", 32'(busyCnt), 32'(busyQ.pop_front()));
                busyCnt = 0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        resetN       = 1'b0;
        globalUpdate = 1'b0;
        wb.cyc  = 1'b0;
        wb.stb  = 1'b0;
        wb.we   = 1'b0;
        wb.adr  = '0;
        wb.datW = '0;
        wb.sel  = '0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("resetBusy", 32'(busy), 32'h0);
        checkOutput("resetCoeffWr", 32'(coeffWr), 32'h0);
        checkOutput("resetCoeffUpd", 32'(coeffUpd), 32'h0);
        checkOutput("resetCoeffDat", 32'(coeffDat), 32'h0);
        checkOutput("resetAck", 32'(wb.ack), 32'h0);
        checkOutput("resetDatR", wb.datR, 32'h0);
        resetN = 1'b1;
        @(posedge clock);
        #1;
        busRead(ADR_CTRL, 32'h0);
        busRead(ADR_PTR, 32'h0);

        $display("[TB] fill shadow RAM");
        busWrite(ADR_PTR, 32'h0);
        for (int i = 0; i < NCH*NCOEFF; i++) begin
            shadow[i] = CBITS'(32'h100 + i);
            busWrite(ADR_COEFF, 32'h100 + i);
        end
        busRead(ADR_PTR, 32'h0);
        busWrite(ADR_PTR, 32'hFFFF_FFE5);
        busRead(7'h74, 32'h5);
        busRead(ADR_COEFF, 32'h105);
        busRead(ADR_PTR, 32'h5);
        busWrite(ADR_PTR, 32'd30);
        busWrite(ADR_COEFF, 32'h0002_ABCD);
        shadow[30] = 18'h2ABCD;
        busRead(ADR_PTR, 32'd31);
        busWrite(ADR_PTR, 32'd30);
        busRead(ADR_COEFF, 32'hFFFE_ABCD);

        $display("[TB] LOAD mask 0101");
        expectStream(0, NCOEFF, 4'b0001);
        expectStream(2, NCOEFF, 4'b0100);
        runQ.push_back(16);
        updQ.push_back(4'b0101);
        busyQ.push_back(18);
        busWrite(ADR_CTRL, 32'h0000_0501);
        waitIdle();
        busRead(ADR_CTRL, 32'h0000_0500);

        $display("[TB] write stalled behind LOAD");
        busWrite(ADR_PTR, 32'd8);
        expectStream(0, NCOEFF, 4'b0001);
        runQ.push_back(8);
        updQ.push_back(4'b0001);
        busyQ.push_back(10);
        busWrite(ADR_CTRL, 32'h0000_0101);
        applyStimulus(1'b1, ADR_COEFF, 32'h55, 32'h0, waited);
        shadow[8] = 18'h55;
        checkOutput("stallAckDelay", 32'(waited), 32'd11);
        checkOutput("busyAtStallAck", 32'(busy), 32'h0);
        busRead(ADR_PTR, 32'd9);
        busWrite(ADR_PTR, 32'd8);
        busRead(ADR_COEFF, 32'h55);

        $display("[TB] global update in IDLE");
        updQ.push_back(4'b1111);
        globalUpdate = 1'b1;
        @(posedge clock);
        #1;
        globalUpdate = 1'b0;
        checkOutput("globalIdleUpd", 32'(coeffUpd), 32'hF);
        @(posedge clock);
        #1;
        checkOutput("globalIdleOnePulse", 32'(coeffUpd), 32'h0);

        $display("[TB] global update during STREAM");
        expectStream(1, NCOEFF, 4'b0010);
        runQ.push_back(8);
        updQ.push_back(4'b1111);
        busyQ.push_back(10);
        busWrite(ADR_CTRL, 32'h0000_0201);
        @(posedge clock);
        #1;
        globalUpdate = 1'b1;
        @(posedge clock);
        #1;
        globalUpdate = 1'b0;
        busRead(ADR_CTRL, 32'h0000_0203);
        waitIdle();
        busRead(ADR_CTRL, 32'h0000_0200);

        $display("[TB] reset during STREAM");
        busWrite(ADR_PTR, 32'd7);
        expectStream(0, 2, 4'b0001);
        runQ.push_back(2);
        busyQ.push_back(3);
        busWrite(ADR_CTRL, 32'h0000_0F01);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        resetN = 1'b0;
        @(posedge clock);
        #1;
        resetN = 1'b1;
        checkOutput("midResetCoeffWr", 32'(coeffWr), 32'h0);
        checkOutput("midResetCoeffUpd", 32'(coeffUpd), 32'h0);
        checkOutput("midResetBusy", 32'(busy), 32'h0);
        checkOutput("midResetCoeffDat", 32'(coeffDat), 32'h0);
        repeat (40) @(posedge clock);
        #1;
        busRead(ADR_PTR, 32'h0);
        busRead(ADR_CTRL, 32'h0);

        $display("[TB] LOAD with empty mask");
        busWrite(ADR_CTRL, 32'h0000_0001);
        for (int i = 0; i < 5; i++) begin
            checkOutput("mask0Busy", 32'(busy), 32'h0);
            @(posedge clock);
            #1;
        end
        busRead(ADR_CTRL, 32'h0);

        $display("[TB] reserved register");
        busWrite(ADR_RSVD, 32'hFFFF_FFFF);
        busRead(ADR_RSVD, 32'h0);
        busRead(ADR_PTR, 32'h0);

        repeat (5) @(posedge clock);
        #1;
        checkOutput("busQEmpty", 32'(busQ.size()), 32'h0);
        checkOutput("wrQEmpty", 32'(wrQ.size()), 32'h0);
        checkOutput("updQEmpty", 32'(updQ.size()), 32'h0);
        checkOutput("busyQEmpty", 32'(busyQ.size()), 32'h0);
        checkOutput("runQEmpty", 32'(runQ.size()), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
